hilo_mul_unit: RTL and testbench

- Iterative multiply / multiply-accumulate unit that owns the HI/LO register pair.
- Sits directly downstream of the ALU in the processor datapath. The ALU control decode issues mul/madd here with the two register operands.
- The unit computes the 64-bit product over multiple cycles and writes or accumulates it into HI/LO.
- It also services direct HI/LO writes and exposes HI/LO for readback.

---
 rtl/hilo_mul_unit_if.sv | 29 ++
 rtl/hilo_mul_unit.sv | 117 +++++++++++
 tb/tb_hilo_mul_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mul_unit_if.sv
// hilo_mul_unit_if: request/write/readback bundle for the HI/LO multiply unit.
//   master : issuer side (drives start/op_madd/signed_op/a/b/wr_*; sees busy/done/hi/lo)
//   slave  : the multiply unit itself
interface hilo_mul_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op_madd;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_madd, signed_op, a, b, wr_hi, wr_lo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_madd, signed_op, a, b, wr_hi, wr_lo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/hilo_mul_unit.sv
// hilo_mul_unit: iterative radix-2 multiply / multiply-accumulate owning HI/LO.
// Ports:
//   i_clk : clock, all state on rising edge
//   i_rst : asynchronous active-low reset
//   bus   : hilo_mul_unit_if.slave (start/op_madd/signed_op/a/b, direct HI/LO writes,
//           busy/done status, hi/lo readback)
// A request spends one accept edge, WIDTH shift-add edges, then one writeback edge.
module hilo_mul_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  hilo_mul_unit_if.slave      bus
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic             r_neg;
  logic             r_madd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [PW-1:0]    w_acc_nxt;
  logic [PW-1:0]    w_prod;
  logic [PW-1:0]    w_sum;
  logic             w_last;

  always_comb begin
    // Most-negative input negates to itself, which read as unsigned is the right magnitude.
    w_a_mag   = (bus.signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    w_b_mag   = (bus.signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    w_prod    = r_neg ? -r_acc : r_acc;
    // Carry out of the accumulate is dropped on purpose (modulo 2^PW).
    w_sum     = {r_hi, r_lo} + w_prod;
    w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_madd   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_madd   <= bus.op_madd;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CALC;
          end else begin
            // Direct writes only when no request competes for the same edge.
            if (bus.wr_hi) r_hi <= bus.wr_data;
            if (bus.wr_lo) r_lo <= bus.wr_data;
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) r_state <= S_WB;
        end
        S_WB: begin
          if (r_madd) begin
            r_hi <= w_sum[PW-1:WIDTH];
            r_lo <= w_sum[WIDTH-1:0];
          end else begin
            r_hi <= w_prod[PW-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_hilo_mul_unit.sv
// tb_hilo_mul_unit: scoreboard bench for hilo_mul_unit. Expected HI:LO values are
// computed from a reference model when a request is issued and compared on done.
module tb_hilo_mul_unit;

  logic clk;
  logic rst;

  hilo_mul_unit_if #(.WIDTH(32)) bus ();

  hilo_mul_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk;
  int          n_err;
  logic [63:0] sb_q[$];
  logic [63:0] m_hilo;
  logic [63:0] mon_exp;
  int          lat;
  int          bcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Scoreboard: every done pulse pops one expected HI:LO.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("result", {bus.hi, bus.lo}, mon_exp);
      end
    end
  end

  // Called at a negedge; returns just after the accepting edge.
  task automatic issue(input logic madd, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic push);
    logic [63:0] p;
    bus.start     = 1'b1;
    bus.op_madd   = madd;
    bus.signed_op = sgn;
    bus.a         = a;
    bus.b         = b;
    if (push) begin
      p      = ref_prod(sgn, a, b);
      m_hilo = madd ? (m_hilo + p) : p;
      sb_q.push_back(m_hilo);
    end
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.op_madd = 1'b0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    // Operands are free to change once accepted.
    bus.a       = $urandom;
    bus.b       = $urandom;
  endtask

  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      l++;
      if (bus.busy) bc++;
      if (bus.done) break;
    end
    if (!bus.done) chk("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    m_hilo = 64'd0;
    bus.start = 1'b0; bus.op_madd = 1'b0; bus.signed_op = 1'b0;
    bus.a = '0; bus.b = '0; bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wr_data = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Unsigned full scale, latency and busy/done shape.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, bcnt);
    chk("latency_full", 64'(lat - 1), 64'd33);
    chk("busy_cycles", 64'(bcnt), 64'd33);
    chk("full_scale", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("done_pulse", {63'd0, bus.done}, 64'd0);

    // Signed mixed sign.
    issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(lat, bcnt);
    chk("signed_mixed", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // mul then madd issued in the done cycle.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'd2, 32'd3, 1'b1);
    wait_done(lat, bcnt);
    chk("mul_2x3", {bus.hi, bus.lo}, 64'd6);
    issue(1'b1, 1'b0, 32'h8000_0000, 32'd2, 1'b1);
    wait_done(lat, bcnt);
    chk("b2b_madd", {bus.hi, bus.lo}, 64'h0000_0001_0000_0006);

    // Accumulate wraps modulo 2^64.
    @(negedge clk);
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    m_hilo = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    chk("direct_write", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(1'b1, 1'b0, 32'd1, 32'd1, 1'b1);
    wait_done(lat, bcnt);
    chk("madd_wrap", {bus.hi, bus.lo}, 64'd0);

    // Most negative squared, then signed madd of a negative product.
    @(negedge clk);
    issue(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(lat, bcnt);
    chk("min_sq", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
    @(negedge clk);
    issue(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1);
    wait_done(lat, bcnt);
    chk("signed_madd", {bus.hi, bus.lo}, 64'h3FFF_FFFF_FFFF_FFFB);

    // start and direct write while busy are ignored.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h100, 32'h100, 1'b1);
    repeat (5) @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd5;
    bus.wr_hi = 1'b1; bus.wr_data = 32'h1234;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.wr_hi = 1'b0;
    wait_done(lat, bcnt);
    chk("busy_ignore", {bus.hi, bus.lo}, 64'h1_0000);
    repeat (40) @(negedge clk);
    chk("no_extra_op", {bus.hi, bus.lo}, 64'h1_0000);
    chk("idle_busy", {63'd0, bus.busy}, 64'd0);

    // start wins over wr_lo in the same idle cycle.
    @(negedge clk);
    bus.wr_lo = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
    issue(1'b1, 1'b0, 32'd3, 32'd4, 1'b1);
    wait_done(lat, bcnt);
    chk("start_wins", {bus.hi, bus.lo}, 64'h1_000C);

    // Zero operand still takes the full latency.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'd0, 32'd5, 1'b1);
    wait_done(lat, bcnt);
    chk("latency_zero", 64'(lat - 1), 64'd33);

    // Reset mid-operation aborts with no partial update.
    @(negedge clk);
    issue(1'b0, 1'b0, 32'h10, 32'h10, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    m_hilo = 64'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(1'b0, 1'b0, 32'd4, 32'd4, 1'b1);
    wait_done(lat, bcnt);
    chk("latency_post_rst", 64'(lat - 1), 64'd33);
    chk("post_rst_mul", {bus.hi, bus.lo}, 64'h10);
    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
